// File: rtl/plic_arbiter_if.sv
// Bus bundle between the interrupt arbiter and its surroundings: peripheral
// request lines, configuration writes, and the core-side request/claim/complete handshake.
interface plic_arbiter_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] src_irq;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [15:0]        cfg_wdata;
  logic               int_req;
  logic [7:0]         int_code;
  logic               claim;
  logic               complete;
  logic [7:0]         complete_code;
  logic               busy;

  modport master (
    output src_irq, cfg_we, cfg_addr, cfg_wdata, claim, complete, complete_code,
    input  int_req, int_code, busy
  );

  modport slave (
    input  src_irq, cfg_we, cfg_addr, cfg_wdata, claim, complete, complete_code,
    output int_req, int_code, busy
  );
endinterface

// File: rtl/plic_arbiter.sv
// Single-flight interrupt arbiter: latches level requests as pending, picks the
// highest-priority eligible source and walks it through request, claim and completion.
module plic_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input logic           clk,
  input logic           rst,
  plic_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                int_req_q, int_req_d;
  logic [7:0]          int_code_q, int_code_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  in_service_q, in_service_d;
  logic [NUM_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0]   thr_q, thr_d;
  logic [PRIO_W-1:0]   prio_q [NUM_SRC];
  logic [PRIO_W-1:0]   prio_d [NUM_SRC];

  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  cur_sel;
  logic [NUM_SRC-1:0]  claim_set;
  logic [NUM_SRC-1:0]  done_clr;
  logic [3:0]          win_idx;
  logic [PRIO_W-1:0]   win_prio;
  logic                any_eligible;
  logic                unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata;

  // cur_sel is the one-hot of the source currently latched in int_code.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign eligible[gi] = pending_q[gi] & enable_q[gi] & (prio_q[gi] > thr_q);
    assign cur_sel[gi]  = (int_code_q == 8'(gi + 1));
  end

  // Strictly-greater compare keeps the lowest index on priority ties.
  always_comb begin
    win_idx      = '0;
    win_prio     = '0;
    any_eligible = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!any_eligible || prio_q[i] > win_prio)) begin
        any_eligible = 1'b1;
        win_prio     = prio_q[i];
        win_idx      = 4'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    int_req_d  = int_req_q;
    int_code_d = int_code_q;
    claim_set  = '0;
    done_clr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          int_code_d = 8'(win_idx) + 8'd1;
          int_req_d  = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.claim) begin
          int_req_d = 1'b0;
          claim_set = cur_sel;
          state_d   = ST_SERVE;
        end else if (!(|(eligible & cur_sel))) begin
          int_req_d  = 1'b0;
          int_code_d = 8'd0;
          state_d    = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (bus.complete && (bus.complete_code == int_code_q)) begin
          done_clr   = cur_sel;
          int_code_d = 8'd0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        int_req_d  = 1'b0;
        int_code_d = 8'd0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // A claim clears pending even if the line is still high that same edge;
  // in_service then holds it off until completion.
  always_comb begin
    pending_d    = (pending_q | (bus.src_irq & ~in_service_q)) & ~claim_set;
    in_service_d = (in_service_q | claim_set) & ~done_clr;
  end

  always_comb begin
    enable_d = enable_q;
    thr_d    = thr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      prio_d[i] = prio_q[i];
    end
    if (bus.cfg_we) begin
      if (bus.cfg_addr == 4'd14) begin
        enable_d = bus.cfg_wdata[NUM_SRC-1:0];
      end else if (bus.cfg_addr == 4'd15) begin
        thr_d = bus.cfg_wdata[PRIO_W-1:0];
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (bus.cfg_addr == 4'(i)) begin
            prio_d[i] = bus.cfg_wdata[PRIO_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      int_code_q   <= 8'd0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      thr_q        <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_code_q   <= int_code_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      thr_q        <= thr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_q[i] <= prio_d[i];
      end
    end
  end

  assign bus.int_req  = int_req_q;
  assign bus.int_code = int_code_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_plic_arbiter.sv
// Directed-vector bench for plic_arbiter: arbitration order, claim/complete
// handshake, eligibility loss, threshold gating and asynchronous reset.
module tb_plic_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  plic_arbiter_if #(.NUM_SRC(8)) bus ();

  plic_arbiter #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic do_claim();
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
  endtask

  task automatic do_complete(input logic [7:0] code);
    bus.complete      = 1'b1;
    bus.complete_code = code;
    tick();
    bus.complete      = 1'b0;
    bus.complete_code = 8'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    bus.src_irq   = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.claim     = 1'b0;
    bus.complete  = 1'b0;
    bus.complete_code = '0;

    #2;
    chk("reset int_req", 32'(bus.int_req), 32'd0);
    chk("reset int_code", 32'(bus.int_code), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle after reset", 32'(bus.busy), 32'd0);

    // Single source, fixed two-edge latency
    cfg_write(4'd2, 16'd3);
    cfg_write(4'd14, 16'h04);
    cfg_write(4'd15, 16'd0);
    bus.src_irq[2] = 1'b1;
    tick();
    chk("lat N+1 int_req", 32'(bus.int_req), 32'd0);
    tick();
    chk("lat N+2 int_req", 32'(bus.int_req), 32'd1);
    chk("lat N+2 int_code", 32'(bus.int_code), 32'd3);
    chk("lat N+2 busy", 32'(bus.busy), 32'd1);

    do_claim();
    chk("claim int_req", 32'(bus.int_req), 32'd0);
    chk("claim busy", 32'(bus.busy), 32'd1);
    chk("claim code held", 32'(bus.int_code), 32'd3);

    do_claim();
    chk("claim in serve ignored", 32'(bus.busy), 32'd1);
    do_complete(8'd4);
    chk("bad complete busy", 32'(bus.busy), 32'd1);
    chk("bad complete code", 32'(bus.int_code), 32'd3);
    do_complete(8'd3);
    chk("complete busy", 32'(bus.busy), 32'd0);
    chk("complete code", 32'(bus.int_code), 32'd0);
    tick();
    chk("re-req +1 int_req", 32'(bus.int_req), 32'd0);
    tick();
    chk("re-req +2 int_req", 32'(bus.int_req), 32'd1);
    chk("re-req +2 int_code", 32'(bus.int_code), 32'd3);

    // Loss of eligibility while requesting
    cfg_write(4'd14, 16'h00);
    tick();
    chk("disable int_req", 32'(bus.int_req), 32'd0);
    chk("disable int_code", 32'(bus.int_code), 32'd0);
    chk("disable busy", 32'(bus.busy), 32'd0);
    cfg_write(4'd14, 16'h04);
    tick();
    chk("re-enable int_req", 32'(bus.int_req), 32'd1);
    chk("re-enable int_code", 32'(bus.int_code), 32'd3);

    // Claim wins over a simultaneous disable
    bus.claim = 1'b1;
    cfg_write(4'd14, 16'h00);
    bus.claim = 1'b0;
    chk("claim+disable busy", 32'(bus.busy), 32'd1);
    chk("claim+disable int_req", 32'(bus.int_req), 32'd0);
    bus.src_irq[2] = 1'b0;
    do_complete(8'd3);
    tick();
    tick();
    chk("quiet after serve", 32'(bus.int_req), 32'd0);

    // Priority order with tie to lowest index, and no preemption
    cfg_write(4'd1, 16'd5);
    cfg_write(4'd4, 16'd5);
    cfg_write(4'd6, 16'd2);
    cfg_write(4'd14, 16'hFF);
    bus.src_irq = 8'b0101_0010;
    tick();
    tick();
    chk("arb first code", 32'(bus.int_code), 32'd2);
    bus.src_irq[1] = 1'b0;
    do_claim();
    do_complete(8'd2);
    chk("arb gap code", 32'(bus.int_code), 32'd0);
    tick();
    chk("arb second int_req", 32'(bus.int_req), 32'd1);
    chk("arb second code", 32'(bus.int_code), 32'd5);
    bus.src_irq[4] = 1'b0;
    do_claim();
    do_complete(8'd5);
    tick();
    chk("arb third code", 32'(bus.int_code), 32'd7);
    bus.src_irq[1] = 1'b1;
    tick();
    tick();
    tick();
    chk("no preempt code", 32'(bus.int_code), 32'd7);
    chk("no preempt int_req", 32'(bus.int_req), 32'd1);
    bus.src_irq[6] = 1'b0;
    do_claim();
    do_complete(8'd7);
    tick();
    chk("late high-prio code", 32'(bus.int_code), 32'd2);
    bus.src_irq[1] = 1'b0;
    do_claim();
    do_complete(8'd2);
    tick();
    chk("arb drained busy", 32'(bus.busy), 32'd0);

    // Threshold gating: priority equal to threshold is not eligible
    cfg_write(4'd14, 16'h01);
    cfg_write(4'd0, 16'd2);
    cfg_write(4'd15, 16'd2);
    cfg_write(4'd10, 16'h7);
    bus.src_irq[0] = 1'b1;
    tick();
    tick();
    tick();
    chk("thr gate int_req", 32'(bus.int_req), 32'd0);
    cfg_write(4'd15, 16'd1);
    tick();
    chk("thr lowered int_req", 32'(bus.int_req), 32'd1);
    chk("thr lowered int_code", 32'(bus.int_code), 32'd1);

    // Asynchronous reset while serving
    do_claim();
    chk("pre-reset busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst int_req", 32'(bus.int_req), 32'd0);
    chk("async rst busy", 32'(bus.busy), 32'd0);
    chk("async rst int_code", 32'(bus.int_code), 32'd0);
    bus.src_irq = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("post-reset busy", 32'(bus.busy), 32'd0);
    chk("post-reset int_req", 32'(bus.int_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
